// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: register map, field positions,
// scan FSM states and the event-encoding helper.
package keypad_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_EVENT  = 2'd2;
  localparam logic [1:0] REG_KEYMAP = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_CNT_LSB  = 4;

  localparam int EVT_VALID = 8;
  localparam int EVT_REL   = 4;
  localparam int EVT_W     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    UPDATE = 2'd2
  } scan_state_e;

  // Index of the lowest set bit; events drain in ascending key order
  function automatic logic [3:0] first_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous event FIFO; a pop frees a slot for a push in the same cycle even when full.
module keypad_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = pop & (count_r != (AW+1)'(0));
  assign do_push_s = push & ((count_r != FULL_CNT) | do_pop_s);

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == (AW+1)'(0));
  assign count = count_r;

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with debounce, event FIFO, APB register file and level IRQ.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  output logic [3:0]  row,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        KeyIRQ
);
  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
  localparam logic [1:0]    DEB_LAST  = 2'(DEB_FRAMES - 1);

  logic [3:0]       col_meta_r, col_sync_r;
  scan_state_e      state_r;
  logic [1:0]       row_idx_r;
  logic [DW-1:0]    dwell_r;
  logic [3:0]       row_r;
  logic [15:0]      frame_r, map_r, pend_r;
  logic [1:0]       cnt_r [16];
  logic             deb_done_r;
  logic [1:0]       ctrl_r;
  logic             ovf_r, irq_r;

  logic [15:0]      tog_s, map_nxt_s, pend_new_s, pend_rest_s;
  logic [1:0]       cnt_nxt_s [16];
  logic [3:0]       push_key_s;
  logic             rel_s, push_s, pop_s, full_s, empty_s;
  logic             access_s, wr_s, rd_s;
  logic [EVT_W-1:0] evt_s, head_s;
  logic [CW-1:0]    count_s;
  logic [4:0]       cnt_ext_s;
  logic             unused_s;

  assign access_s = PSEL & PENABLE;
  assign wr_s     = access_s & PWRITE;
  assign rd_s     = access_s & ~PWRITE;
  assign pop_s    = rd_s & (PADDR[3:2] == REG_EVENT) & ~empty_s;

  assign push_key_s  = first_set(pend_r);
  assign pend_rest_s = pend_r & ~(16'd1 << push_key_s);
  assign push_s      = (state_r == UPDATE) & deb_done_r & (pend_r != 16'd0);
  assign evt_s       = {rel_s, push_key_s};
  assign cnt_ext_s   = 5'(count_s);
  assign unused_s    = ^{PADDR[1:0], PWDATA[31:3], cnt_ext_s[4]};

`ifdef KEYPAD_RELEASE_EVT_EN
  assign pend_new_s = tog_s;
  assign rel_s      = ~map_r[push_key_s];
`else
  assign pend_new_s = tog_s & map_nxt_s;
  assign rel_s      = 1'b0;
`endif

  assign row    = row_r;
  assign KeyIRQ = irq_r;
  assign PREADY = 1'b1;

  keypad_evt_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (evt_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Column double-flop synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_r <= 4'd0;
      col_sync_r <= 4'd0;
    end else begin
      col_meta_r <= col_in;
      col_sync_r <= col_meta_r;
    end
  end

  // Per-key debounce decision for the frame just captured
  always_comb begin
    tog_s = 16'd0;
    for (int k = 0; k < 16; k++) begin
      cnt_nxt_s[k] = 2'd0;
      if (frame_r[k] == map_r[k]) begin
        cnt_nxt_s[k] = 2'd0;
      end else if (cnt_r[k] == DEB_LAST) begin
        tog_s[k] = 1'b1;
      end else begin
        cnt_nxt_s[k] = cnt_r[k] + 2'd1;
      end
    end
    map_nxt_s = map_r ^ tog_s;
  end

  // Scan sequencer: row drive, frame capture, debounce and event drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      row_r      <= 4'd0;
      row_idx_r  <= 2'd0;
      dwell_r    <= DW'(0);
      frame_r    <= 16'd0;
      map_r      <= 16'd0;
      pend_r     <= 16'd0;
      deb_done_r <= 1'b0;
      for (int k = 0; k < 16; k++) cnt_r[k] <= 2'd0;
    end else if (!ctrl_r[CTRL_EN]) begin
      state_r    <= IDLE;
      row_r      <= 4'd0;
      row_idx_r  <= 2'd0;
      dwell_r    <= DW'(0);
      frame_r    <= 16'd0;
      pend_r     <= 16'd0;
      deb_done_r <= 1'b0;
      for (int k = 0; k < 16; k++) cnt_r[k] <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= DRIVE;
          row_idx_r <= 2'd0;
          dwell_r   <= DWELL_MAX;
          row_r     <= 4'b0001;
        end
        DRIVE: begin
          if (dwell_r == DW'(0)) begin
            frame_r[{row_idx_r, 2'b00} +: 4] <= col_sync_r;
            if (row_idx_r == 2'd3) begin
              state_r    <= UPDATE;
              row_r      <= 4'd0;
              deb_done_r <= 1'b0;
            end else begin
              row_idx_r <= row_idx_r + 2'd1;
              row_r     <= {row_r[2:0], 1'b0};
              dwell_r   <= DWELL_MAX;
            end
          end else begin
            dwell_r <= dwell_r - DW'(1);
          end
        end
        UPDATE: begin
          // First cycle commits the debounce; later cycles push one event each
          if (!deb_done_r) begin
            map_r <= map_nxt_s;
            cnt_r <= cnt_nxt_s;
            if (pend_new_s == 16'd0) begin
              state_r   <= DRIVE;
              row_idx_r <= 2'd0;
              dwell_r   <= DWELL_MAX;
              row_r     <= 4'b0001;
            end else begin
              pend_r     <= pend_new_s;
              deb_done_r <= 1'b1;
            end
          end else begin
            pend_r <= pend_rest_s;
            if (pend_rest_s == 16'd0) begin
              state_r    <= DRIVE;
              row_idx_r  <= 2'd0;
              dwell_r    <= DWELL_MAX;
              row_r      <= 4'b0001;
              deb_done_r <= 1'b0;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Control, sticky overflow and interrupt registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= 2'd0;
      ovf_r  <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_s && (PADDR[3:2] == REG_CTRL)) ctrl_r <= PWDATA[1:0];
      if (push_s && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && (PADDR[3:2] == REG_STATUS) && PWDATA[ST_OVF]) begin
        ovf_r <= 1'b0;
      end
      irq_r <= ctrl_r[CTRL_IRQ_EN] & (~empty_s | ovf_r);
    end
  end

  // Register read mux
  always_comb begin
    PRDATA = 32'd0;
    case (PADDR[3:2])
      REG_CTRL:   PRDATA = {30'd0, ctrl_r};
      REG_STATUS: PRDATA = {24'd0, cnt_ext_s[3:0], 1'b0, ovf_r, full_s, ~empty_s};
      REG_EVENT:  PRDATA = empty_s ? 32'd0 : {23'd0, 1'b1, 3'd0, head_s};
      REG_KEYMAP: PRDATA = {16'd0, map_r};
      default:    PRDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEB_FRAMES=3, FIFO_DEPTH=8).
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, KeyIRQ;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic [15:0] map;
    int          nevt;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] rs [18];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_FRAMES(3), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row(row),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .KeyIRQ(KeyIRQ)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its driven row to its column
  always_comb begin
    col_in = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (row[r]) col_in = col_in | keys[r*4 +: 4];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    chk(name, d, exp);
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    bit seen;
    seen = 1'b0;
    prev = row;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (row == 4'b0001 && prev == 4'b0000) seen = 1'b1;
      prev = row;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_start: got no frame start within 100 cycles, required one");
    end
  endtask

  // Pop the DUT event FIFO until empty, comparing against the scoreboard
  task automatic drain(input string name);
    logic [31:0] d;
    logic [31:0] e;
    bit got_empty;
    got_empty = 1'b0;
    for (int n = 0; n < 20 && !got_empty; n++) begin
      apb_read(4'h8, d);
      if (!d[8]) begin
        got_empty = 1'b1;
        chk({name, " empty_read"}, d, 32'h0);
      end else if (exp_q.size() == 0) begin
        chk({name, " unexpected_event"}, d, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk({name, " event"}, d, e);
      end
    end
    chk({name, " drained"}, 32'(got_empty), 32'd1);
    chk({name, " missing_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_vec(input int i);
    if (vecs[i].nevt >= 1) exp_q.push_back(vecs[i].e0);
    if (vecs[i].nevt >= 2) exp_q.push_back(vecs[i].e1);
  endtask

  initial begin
    vecs[0] = '{16'h0040, 5, 16'h0040, 1, 32'h106, 32'h0};
    vecs[1] = '{16'h0000, 5, 16'h0000, REL ? 1 : 0, 32'h116, 32'h0};
    vecs[2] = '{16'h0040, 1, 16'h0000, 0, 32'h0, 32'h0};
    vecs[3] = '{16'h0000, 4, 16'h0000, 0, 32'h0, 32'h0};
    vecs[4] = '{16'h0040, 2, 16'h0000, 0, 32'h0, 32'h0};
    vecs[5] = '{16'h0000, 3, 16'h0000, 0, 32'h0, 32'h0};
    vecs[6] = '{16'h8001, 3, 16'h8001, 2, 32'h100, 32'h10F};
    vecs[7] = '{16'h0000, 4, 16'h0000, REL ? 2 : 0, 32'h110, 32'h11F};
    rs = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4,
           4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 4'h0; PWDATA = 32'h0; keys = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset row", 32'(row), 32'h0);
    chk("reset irq", 32'(KeyIRQ), 32'h0);
    chk("pready", 32'(PREADY), 32'h1);
    rd_chk("reset ctrl", 4'h0, 32'h0);
    rd_chk("reset status", 4'h4, 32'h0);
    rd_chk("reset event", 4'h8, 32'h0);
    rd_chk("reset keymap", 4'hC, 32'h0);
    chk("idle row", 32'(row), 32'h0);

    // Row sequence after enable
    apb_write(4'h0, 32'h1);
    wait_frame_start();
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("row_seq[%0d]", i), 32'(row), 32'(rs[i]));
    end

    // Debounce vectors; keys change only at frame starts
    wait_frame_start();
    keys = vecs[0].keys;
    push_vec(0);
    for (int i = 0; i < 8; i++) begin
      repeat (vecs[i].frames) wait_frame_start();
      keys = (i < 7) ? vecs[i+1].keys : 16'h0;
      rd_chk($sformatf("vec%0d keymap", i), 4'hC, 32'(vecs[i].map));
      drain($sformatf("vec%0d", i));
      if (i < 7) push_vec(i + 1);
    end

    // Overflow: nine simultaneous presses into an eight-entry FIFO
    apb_write(4'h0, 32'h3);
    wait_frame_start();
    keys = 16'h80FF;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h100 + 32'(k));
    repeat (3) wait_frame_start();
    chk("ovf irq", 32'(KeyIRQ), 32'h1);
    rd_chk("ovf status", 4'h4, 32'h87);
    rd_chk("ovf keymap", 4'hC, 32'h80FF);
    apb_write(4'h4, 32'h4);
    rd_chk("w1c status", 4'h4, 32'h83);
    drain("ovf");
    repeat (2) @(negedge clk);
    chk("irq cleared", 32'(KeyIRQ), 32'h0);
    rd_chk("drained status", 4'h4, 32'h0);

    wait_frame_start();
    keys = 16'h0;
    for (int k = 0; k < 8; k++) if (REL) exp_q.push_back(32'h110 + 32'(k));
    repeat (3) wait_frame_start();
    rd_chk("release keymap", 4'hC, 32'h0);
    rd_chk("release status", 4'h4, REL ? 32'h87 : 32'h0);
    apb_write(4'h4, 32'h4);
    drain("release");
    rd_chk("release end status", 4'h4, 32'h0);

    // Disable mid-DRIVE with one event queued
    wait_frame_start();
    keys = 16'h0040;
    exp_q.push_back(32'h106);
    repeat (3) wait_frame_start();
    repeat (5) @(negedge clk);
    chk("pre-disable row", 32'(row), 32'h2);
    apb_write(4'h0, 32'h2);
    @(negedge clk);
    chk("disable row", 32'(row), 32'h0);
    chk("disable irq", 32'(KeyIRQ), 32'h1);
    rd_chk("disable keymap", 4'hC, 32'h40);
    rd_chk("disable status", 4'h4, 32'h11);
    repeat (20) @(negedge clk);
    chk("disabled row stays", 32'(row), 32'h0);
    exp_q.delete();

    // Reset mid-scan
    apb_write(4'h0, 32'h3);
    wait_frame_start();
    repeat (7) @(negedge clk);
    chk("pre-reset row", 32'(row), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("async reset row", 32'(row), 32'h0);
    chk("async reset irq", 32'(KeyIRQ), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst ctrl", 4'h0, 32'h0);
    rd_chk("rst status", 4'h4, 32'h0);
    rd_chk("rst keymap", 4'hC, 32'h0);
    rd_chk("rst event", 4'h8, 32'h0);
    repeat (30) @(negedge clk);
    chk("rst row idle", 32'(row), 32'h0);
    keys = 16'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
